// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: transaction controller for the vending datapath.
// Accepts coin events into a credit register, checks the price of the
// selected item, sequences the dispense pulse and the change return, and
// enforces cancel and an inactivity timeout. Only one operation reaches the
// datapath at a time; coins arriving while busy are refused.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   coin_vld   in   one-cycle coin-accepted strobe
//   coin_val   in   coin value, qualified by coin_vld
//   buy_req    in   one-cycle purchase request
//   sel        in   item select, sampled with buy_req
//   cancel     in   one-cycle refund request
//   balance    out  current credit (registered)
//   dispense   out  product release, held DISP_CYCLES cycles
//   disp_sel   out  item being dispensed, valid while dispense=1
//   change_vld out  one-cycle refund strobe
//   change_amt out  refund value with change_vld, else 0
//   busy       out  high in CHECK, DISPENSE, CHANGE
//   coin_rej   out  one-cycle pulse: coin refused
//   err_insuf  out  one-cycle pulse: purchase refused, insufficient credit
module vend_txn_ctrl #(
    parameter int                   BAL_W          = 4,
    parameter int                   MAX_BAL        = 15,
    parameter logic [4*BAL_W-1:0]   PRICES         = 16'hCA75,
    parameter int                   DISP_CYCLES    = 4,
    parameter int                   TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_vld,
    input  logic [BAL_W-1:0] coin_val,
    input  logic             buy_req,
    input  logic [1:0]       sel,
    input  logic             cancel,
    output logic [BAL_W-1:0] balance,
    output logic             dispense,
    output logic [1:0]       disp_sel,
    output logic             change_vld,
    output logic [BAL_W-1:0] change_amt,
    output logic             busy,
    output logic             coin_rej,
    output logic             err_insuf
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DC_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [BAL_W:0]  MAX_EXT   = (BAL_W+1)'(MAX_BAL);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DC_W-1:0] DISP_LAST = DC_W'(DISP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_CHECK,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t           r_state, w_state_nx;
    logic [BAL_W-1:0] r_balance, w_balance_nx;
    logic             r_dispense, w_dispense_nx;
    logic [1:0]       r_disp_sel, w_disp_sel_nx;
    logic [1:0]       r_sel, w_sel_nx;
    logic             r_change_vld, w_change_vld_nx;
    logic [BAL_W-1:0] r_change_amt, w_change_amt_nx;
    logic             r_busy, w_busy_nx;
    logic             r_coin_rej, w_coin_rej_nx;
    logic             r_err_insuf, w_err_insuf_nx;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nx;
    logic [DC_W-1:0]  r_disp_cnt, w_disp_cnt_nx;

    logic [BAL_W:0]   w_sum;
    logic [BAL_W-1:0] w_price;
    logic             w_coin_fits;

    // Extra sum bit keeps an over-limit add from wrapping into a small value.
    assign w_sum       = {1'b0, r_balance} + {1'b0, coin_val};
    assign w_coin_fits = (w_sum <= MAX_EXT);
    assign w_price     = PRICES[int'(r_sel)*BAL_W +: BAL_W];

    always_comb begin
        w_state_nx      = r_state;
        w_balance_nx    = r_balance;
        w_dispense_nx   = 1'b0;
        w_disp_sel_nx   = 2'b00;
        w_sel_nx        = r_sel;
        w_change_vld_nx = 1'b0;
        w_change_amt_nx = '0;
        w_coin_rej_nx   = 1'b0;
        w_err_insuf_nx  = 1'b0;
        w_to_cnt_nx     = r_to_cnt;
        w_disp_cnt_nx   = r_disp_cnt;

        case (r_state)
            S_IDLE: begin
                if (coin_vld) begin
                    if ({1'b0, coin_val} > MAX_EXT) begin
                        w_coin_rej_nx = 1'b1;
                    end else if (coin_val != '0) begin
                        w_balance_nx = coin_val;
                        w_to_cnt_nx  = '0;
                        w_state_nx   = S_CREDIT;
                    end
                end
            end

            S_CREDIT: begin
                if (cancel) begin
                    w_coin_rej_nx   = coin_vld;
                    w_change_vld_nx = 1'b1;
                    w_change_amt_nx = r_balance;
                    w_balance_nx    = '0;
                    w_state_nx      = S_CHANGE;
                end else if (buy_req) begin
                    w_coin_rej_nx = coin_vld;
                    w_sel_nx      = sel;
                    w_state_nx    = S_CHECK;
                end else if (coin_vld && w_coin_fits) begin
                    w_balance_nx = w_sum[BAL_W-1:0];
                    w_to_cnt_nx  = '0;
                end else begin
                    // An over-limit coin is not an accepted event, so the
                    // idle count keeps running through it.
                    w_coin_rej_nx = coin_vld;
                    if (r_to_cnt == TO_LAST) begin
                        w_change_vld_nx = 1'b1;
                        w_change_amt_nx = r_balance;
                        w_balance_nx    = '0;
                        w_state_nx      = S_CHANGE;
                    end else begin
                        w_to_cnt_nx = r_to_cnt + TO_W'(1);
                    end
                end
            end

            S_CHECK: begin
                w_coin_rej_nx = coin_vld;
                if (r_balance >= w_price) begin
                    w_balance_nx  = r_balance - w_price;
                    w_dispense_nx = 1'b1;
                    w_disp_sel_nx = r_sel;
                    w_disp_cnt_nx = '0;
                    w_state_nx    = S_DISPENSE;
                end else begin
                    w_err_insuf_nx = 1'b1;
                    w_to_cnt_nx    = '0;
                    w_state_nx     = S_CREDIT;
                end
            end

            S_DISPENSE: begin
                w_coin_rej_nx = coin_vld;
                if (r_disp_cnt == DISP_LAST) begin
                    if (r_balance != '0) begin
                        w_change_vld_nx = 1'b1;
                        w_change_amt_nx = r_balance;
                        w_balance_nx    = '0;
                        w_state_nx      = S_CHANGE;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_disp_cnt_nx = r_disp_cnt + DC_W'(1);
                    w_dispense_nx = 1'b1;
                    w_disp_sel_nx = r_sel;
                end
            end

            S_CHANGE: begin
                w_coin_rej_nx = coin_vld;
                w_state_nx    = S_IDLE;
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx == S_CHECK) || (w_state_nx == S_DISPENSE) ||
                    (w_state_nx == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_balance    <= '0;
            r_dispense   <= 1'b0;
            r_disp_sel   <= 2'b00;
            r_sel        <= 2'b00;
            r_change_vld <= 1'b0;
            r_change_amt <= '0;
            r_busy       <= 1'b0;
            r_coin_rej   <= 1'b0;
            r_err_insuf  <= 1'b0;
            r_to_cnt     <= '0;
            r_disp_cnt   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_balance    <= w_balance_nx;
            r_dispense   <= w_dispense_nx;
            r_disp_sel   <= w_disp_sel_nx;
            r_sel        <= w_sel_nx;
            r_change_vld <= w_change_vld_nx;
            r_change_amt <= w_change_amt_nx;
            r_busy       <= w_busy_nx;
            r_coin_rej   <= w_coin_rej_nx;
            r_err_insuf  <= w_err_insuf_nx;
            r_to_cnt     <= w_to_cnt_nx;
            r_disp_cnt   <= w_disp_cnt_nx;
        end
    end

    assign balance    = r_balance;
    assign dispense   = r_dispense;
    assign disp_sel   = r_disp_sel;
    assign change_vld = r_change_vld;
    assign change_amt = r_change_amt;
    assign busy       = r_busy;
    assign coin_rej   = r_coin_rej;
    assign err_insuf  = r_err_insuf;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: bench for vend_txn_ctrl (timeout shortened to 20 cycles).
// A transaction-level reference model predicts, per clock edge, the values
// every output must show after that edge. Accepted purchases and refunds are
// scheduled ahead into per-cycle expectation tables; the bench then plays a
// directed scenario list followed by randomized traffic.
module tb_vend_txn_ctrl;

    localparam int T_OUT = 20;
    localparam int D_CYC = 4;
    localparam int MAXB  = 15;
    localparam int NCYC  = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_vld = 1'b0;
    logic [3:0] coin_val = '0;
    logic       buy_req = 1'b0;
    logic [1:0] sel = '0;
    logic       cancel = 1'b0;
    logic [3:0] balance;
    logic       dispense;
    logic [1:0] disp_sel;
    logic       change_vld;
    logic [3:0] change_amt;
    logic       busy;
    logic       coin_rej;
    logic       err_insuf;

    vend_txn_ctrl #(
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_vld   (coin_vld),
        .coin_val   (coin_val),
        .buy_req    (buy_req),
        .sel        (sel),
        .cancel     (cancel),
        .balance    (balance),
        .dispense   (dispense),
        .disp_sel   (disp_sel),
        .change_vld (change_vld),
        .change_amt (change_amt),
        .busy       (busy),
        .coin_rej   (coin_rej),
        .err_insuf  (err_insuf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs after each edge.
    int ebal [NCYC+16];
    int edisp[NCYC+16];
    int esel [NCYC+16];
    int echg [NCYC+16];
    int ebusy[NCYC+16];
    int erej [NCYC+16];
    int eins [NCYC+16];

    int price[4] = '{5, 7, 10, 12};
    int credit   = 0;
    bit holding  = 1'b0;  // customer credit present, machine waiting
    int busy_end = -1;    // last edge whose outputs were scheduled in advance
    int last_evt = 0;     // edge of the most recent accepted credit event

    task automatic put(input int n, input int bal, input int d, input int s,
                       input int chg, input int bz);
        ebal[n] = bal; edisp[n] = d; esel[n] = s; echg[n] = chg;
        ebusy[n] = bz; erej[n] = 0; eins[n] = 0;
    endtask

    task automatic refund(input int n);
        put(n, 0, 0, 0, credit, 1);
        put(n + 1, 0, 0, 0, 0, 0);
        credit = 0; holding = 1'b0; busy_end = n + 1;
    endtask

    task automatic purchase(input int n, input int s);
        put(n, credit, 0, 0, 0, 1);
        if (credit >= price[s]) begin
            credit -= price[s];
            for (int k = 1; k <= D_CYC; k++) put(n + k, credit, 1, s, 0, 1);
            if (credit != 0) begin
                put(n + D_CYC + 1, 0, 0, 0, credit, 1);
                put(n + D_CYC + 2, 0, 0, 0, 0, 0);
                busy_end = n + D_CYC + 2;
            end else begin
                put(n + D_CYC + 1, 0, 0, 0, 0, 0);
                busy_end = n + D_CYC + 1;
            end
            credit = 0; holding = 1'b0;
        end else begin
            put(n + 1, credit, 0, 0, 0, 0);
            eins[n + 1] = 1;
            busy_end = n + 1;
            last_evt = n + 1;
        end
    endtask

    task automatic model_edge(input bit r, input bit cv, input int cval,
                              input bit b, input int s, input bit c);
        int t;
        bit acc;
        t = cyc;
        if (r) begin
            put(t, 0, 0, 0, 0, 0);
            credit = 0; holding = 1'b0; busy_end = -1;
        end else if (t <= busy_end) begin
            erej[t] = int'(cv);
        end else if (!holding) begin
            if (cv && cval != 0 && cval <= MAXB) begin
                credit = cval; holding = 1'b1; last_evt = t;
            end
            put(t, credit, 0, 0, 0, 0);
            erej[t] = int'(cv && cval > MAXB);
        end else if (c) begin
            refund(t);
            erej[t] = int'(cv);
        end else if (b) begin
            purchase(t, s);
            erej[t] = int'(cv);
        end else begin
            acc = cv && (credit + cval <= MAXB);
            if (acc) begin
                credit += cval; last_evt = t;
            end
            if (!acc && t - last_evt >= T_OUT) refund(t);
            else put(t, credit, 0, 0, 0, 0);
            erej[t] = int'(cv && !acc);
        end
    endtask

    task automatic step(input bit r, input bit cv, input int cval,
                        input bit b, input int s, input bit c);
        rst = r; coin_vld = cv; coin_val = cval[3:0];
        buy_req = b; sel = s[1:0]; cancel = c;
        @(posedge clk);
        model_edge(r, cv, cval, b, s, c);
        #1;
        check_val("balance",    int'(balance),    ebal[cyc]);
        check_val("dispense",   int'(dispense),   edisp[cyc]);
        check_val("disp_sel",   int'(disp_sel),   esel[cyc]);
        check_val("change_vld", int'(change_vld), int'(echg[cyc] != 0));
        check_val("change_amt", int'(change_amt), echg[cyc]);
        check_val("busy",       int'(busy),       ebusy[cyc]);
        check_val("coin_rej",   int'(coin_rej),   erej[cyc]);
        check_val("err_insuf",  int'(err_insuf),  eins[cyc]);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int v);
        step(0, 1, v, 0, 0, 0);
    endtask

    task automatic buy(input int s);
        step(0, 0, 0, 1, s, 0);
    endtask

    initial begin
        // Reset, coins 5+5, buy item 1 (price 7): dispense then change 3.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        coin(5); coin(5); buy(1); idle(8);
        // Insufficient credit for item 3, top up by 2, exact purchase.
        coin(10); buy(3); idle(3); coin(2); buy(3); idle(8);
        // Over-limit coin refused, fill to 15, coin during dispense refused.
        coin(12); coin(5); coin(3); buy(0); idle(2); coin(1); idle(8);
        // Cancel beats a simultaneous buy.
        coin(8); step(0, 0, 0, 1, 2, 1); idle(3);
        // Timeout: a zero-value coin at idle cycle 19 restarts the count.
        coin(4); idle(18); coin(0); idle(T_OUT + 3);
        // Reset during the second dispense cycle discards the credit.
        coin(10); buy(0); idle(2); step(1, 0, 0, 0, 0, 0); idle(3);

        // Randomized traffic in segments of varying activity.
        for (int seg = 0; seg < 60; seg++) begin
            int lvl;
            lvl = $urandom_range(0, 3);
            for (int i = 0; i < 50; i++) begin
                bit r, cv, b, c;
                int cval, s;
                r    = ($urandom_range(0, 399) == 0);
                cv   = (lvl != 0) && ($urandom_range(0, 9) < 2 * lvl);
                cval = $urandom_range(0, 15);
                b    = (lvl != 0) && ($urandom_range(0, 19) < lvl);
                s    = $urandom_range(0, 3);
                c    = (lvl != 0) && ($urandom_range(0, 49) < lvl);
                step(r, cv, cval, b, s, c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
